// File: rtl/jelly2_rtos_pkg.sv
// Shared types for the jelly2 RTOS blocks.
package jelly2_rtos_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

endpackage

// File: rtl/jelly2_rtos_queue.sv
// Wait queue for RTOS objects: ordered list of task ids, entry 0 is always the next task to release.
module jelly2_rtos_queue #(
    parameter bit PRIORITY_ORDER = 1'b1,
    parameter int QUE_SIZE       = 16,
    parameter int ID_WIDTH       = 4,
    parameter int PRI_WIDTH      = 4,
    parameter int QUE_WIDTH      = $clog2(QUE_SIZE + 1)
) (
    input  logic                 reset,
    input  logic                 clk,
    input  logic                 cke,
    input  logic [ID_WIDTH-1:0]  add_id,
    input  logic [PRI_WIDTH-1:0] add_pri,
    input  logic                 add_valid,
    input  logic [ID_WIDTH-1:0]  remove_id,
    input  logic                 remove_valid,
    output logic [ID_WIDTH-1:0]  top_id,
    output logic                 top_valid,
    output logic [QUE_WIDTH-1:0] count
);

    logic [ID_WIDTH-1:0]  ids_q  [QUE_SIZE];
    logic [PRI_WIDTH-1:0] pris_q [QUE_SIZE];
    logic [QUE_WIDTH-1:0] count_q;

    logic [ID_WIDTH-1:0]  ids_n  [QUE_SIZE];
    logic [PRI_WIDTH-1:0] pris_n [QUE_SIZE];
    logic [QUE_WIDTH-1:0] count_n;

    logic [QUE_WIDTH-1:0] ins_pos;
    logic [QUE_WIDTH-1:0] rem_pos;
    logic                 ins_found;
    logic                 rem_found;

    // Lower priority value wins; equal priorities keep arrival order, so insertion goes after them.
    always_comb begin
        ins_pos   = count_q;
        ins_found = 1'b0;
        rem_pos   = '0;
        rem_found = 1'b0;
        for (int i = 0; i < QUE_SIZE; i++) begin
            if (PRIORITY_ORDER && !ins_found && QUE_WIDTH'(i) < count_q && pris_q[i] > add_pri) begin
                ins_pos   = QUE_WIDTH'(i);
                ins_found = 1'b1;
            end
            if (!rem_found && QUE_WIDTH'(i) < count_q && ids_q[i] == remove_id) begin
                rem_pos   = QUE_WIDTH'(i);
                rem_found = 1'b1;
            end
        end
    end

    always_comb begin
        ids_n   = ids_q;
        pris_n  = pris_q;
        count_n = count_q;
        if (add_valid && count_q < QUE_WIDTH'(QUE_SIZE)) begin
            for (int i = 1; i < QUE_SIZE; i++) begin
                if (QUE_WIDTH'(i) > ins_pos) begin
                    ids_n[i]  = ids_q[i-1];
                    pris_n[i] = pris_q[i-1];
                end
            end
            for (int i = 0; i < QUE_SIZE; i++) begin
                if (QUE_WIDTH'(i) == ins_pos) begin
                    ids_n[i]  = add_id;
                    pris_n[i] = add_pri;
                end
            end
            count_n = count_q + 1'b1;
        end else if (remove_valid && rem_found) begin
            for (int i = 0; i < QUE_SIZE - 1; i++) begin
                if (QUE_WIDTH'(i) >= rem_pos) begin
                    ids_n[i]  = ids_q[i+1];
                    pris_n[i] = pris_q[i+1];
                end
            end
            count_n = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QUE_SIZE; i++) begin
                ids_q[i]  <= '0;
                pris_q[i] <= '0;
            end
            count_q <= '0;
        end else if (cke) begin
            ids_q   <= ids_n;
            pris_q  <= pris_n;
            count_q <= count_n;
        end
    end

    assign top_id    = ids_q[0];
    assign top_valid = (count_q != '0);
    assign count     = count_q;

endmodule

// File: rtl/jelly2_rtos_semaphore.sv
// Counting semaphore: grants resources immediately, parks blocked tasks in a wait queue, wakes the top waiter on signal.
module jelly2_rtos_semaphore
    import jelly2_rtos_pkg::*;
#(
    parameter bit PRIORITY_ORDER = 1'b1,
    parameter int QUE_SIZE       = 16,
    parameter int ID_WIDTH       = 4,
    parameter int PRI_WIDTH      = 4,
    parameter int SEM_MAX        = 255,
    parameter int SEM_WIDTH      = $clog2(SEM_MAX + 1),
    parameter int INIT_COUNT     = 0,
    parameter int QUE_WIDTH      = $clog2(QUE_SIZE + 1)
) (
    input  logic                 reset_n,
    input  logic                 clk,
    input  logic                 cke,
    input  logic [ID_WIDTH-1:0]  wait_id,
    input  logic [PRI_WIDTH-1:0] wait_pri,
    input  logic                 wait_valid,
    output logic                 wait_ready,
    input  logic                 signal_valid,
    output logic                 signal_ready,
    input  logic [ID_WIDTH-1:0]  cancel_id,
    input  logic                 cancel_valid,
    output logic                 cancel_ready,
    output logic [ID_WIDTH-1:0]  acquire_id,
    output logic                 acquire_valid,
    output logic                 error,
    output logic [SEM_WIDTH-1:0] sem_count,
    output logic [QUE_WIDTH-1:0] que_count,
    output logic                 busy
);

    state_t               state;
    state_t               state_next;
    logic                 signal_fire;
    logic                 cancel_fire;
    logic                 wait_fire;
    logic                 que_add;
    logic                 que_remove;
    logic [ID_WIDTH-1:0]  que_remove_id;
    logic [ID_WIDTH-1:0]  top_id;
    logic                 top_valid;
    logic [QUE_WIDTH-1:0] queue_count;
    logic                 que_full;

    jelly2_rtos_queue #(
        .PRIORITY_ORDER (PRIORITY_ORDER),
        .QUE_SIZE       (QUE_SIZE),
        .ID_WIDTH       (ID_WIDTH),
        .PRI_WIDTH      (PRI_WIDTH),
        .QUE_WIDTH      (QUE_WIDTH)
    ) u_queue (
        .reset        (~reset_n),
        .clk          (clk),
        .cke          (cke),
        .add_id       (wait_id),
        .add_pri      (wait_pri),
        .add_valid    (que_add),
        .remove_id    (que_remove_id),
        .remove_valid (que_remove),
        .top_id       (top_id),
        .top_valid    (top_valid),
        .count        (queue_count)
    );

    assign busy      = (state != IDLE);
    assign que_count = queue_count;
    assign que_full  = (queue_count >= QUE_WIDTH'(QUE_SIZE));

    // One transfer per cycle with signal > cancel > wait precedence.
    always_comb begin
        signal_ready  = cke & ~busy;
        cancel_ready  = cke & ~busy & ~signal_valid;
        wait_ready    = cke & ~busy & ~signal_valid & ~cancel_valid;
        signal_fire   = signal_valid & signal_ready;
        cancel_fire   = cancel_valid & cancel_ready;
        wait_fire     = wait_valid & wait_ready;
        que_add       = wait_fire & (sem_count == '0) & ~que_full;
        que_remove    = (signal_fire & top_valid) | cancel_fire;
        que_remove_id = signal_fire ? top_id : cancel_id;
        state_next    = IDLE;
        if (state == IDLE && ((signal_fire && top_valid) || cancel_fire)) begin
            state_next = SETTLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            sem_count     <= SEM_WIDTH'(INIT_COUNT);
            acquire_id    <= '0;
            acquire_valid <= 1'b0;
            error         <= 1'b0;
        end else if (!cke) begin
            acquire_valid <= 1'b0;
            error         <= 1'b0;
        end else begin
            state         <= state_next;
            acquire_valid <= 1'b0;
            error         <= 1'b0;
            if (signal_fire) begin
                if (top_valid) begin
                    acquire_id    <= top_id;
                    acquire_valid <= 1'b1;
                end else if (sem_count < SEM_WIDTH'(SEM_MAX)) begin
                    sem_count <= sem_count + 1'b1;
                end else begin
                    error <= 1'b1;
                end
            end else if (wait_fire) begin
                if (sem_count != '0) begin
                    sem_count     <= sem_count - 1'b1;
                    acquire_id    <= wait_id;
                    acquire_valid <= 1'b1;
                end else if (que_full) begin
                    error <= 1'b1;
                end
            end
        end
    end

endmodule
